// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, x/y scan counters, and registered
// active-low syncs plus blanked colour, all delayed one pixel behind the counters.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int unsigned CW           = 10;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             x_last;
    logic             y_last;
    logic             hsync_zone;
    logic             vsync_zone;

    // Decodes of the current counter position.
    always_comb begin
        div_last    = (div_cnt == DIV_W'(CLK_DIV - 1));
        x_last      = (vga_x == CW'(H_TOTAL - 1));
        y_last      = (vga_y == CW'(V_TOTAL - 1));
        hsync_zone  = (vga_x >= CW'(H_SYNC_START)) && (vga_x <= CW'(H_SYNC_END));
        vsync_zone  = (vga_y >= CW'(V_SYNC_START)) && (vga_y <= CW'(V_SYNC_END));
        video_on    = (vga_x < CW'(H_ACTIVE)) && (vga_y < CW'(V_ACTIVE));
        // Gated by reset so the enable is quiet for the whole reset window.
        pixel_tick  = div_last && !reset;
        frame_start = pixel_tick && (vga_x == '0) && (vga_y == '0);
    end

    // Everything advances only on the pixel enable; outputs lag the counters by one pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            vga_x   <= '0;
            vga_y   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
            if (pixel_tick) begin
                vga_x <= x_last ? '0 : vga_x + CW'(1);
                if (x_last) begin
                    vga_y <= y_last ? '0 : vga_y + CW'(1);
                end
                hsync <= !hsync_zone;
                vsync <= !vsync_zone;
                vga_r <= video_on ? red_in   : '0;
                vga_g <= video_on ? green_in : '0;
                vga_b <= video_on ? blue_in  : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for reset/line behaviour and
// a shrunken-raster instance (CLK_DIV=2, 15x11) checked over two whole frames.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic [3:0] r0_in, g0_in, b0_in;
    logic [3:0] r1_in, g1_in, b1_in;

    logic [9:0] d0_x, d0_y, d1_x, d1_y;
    logic       d0_vid, d0_tick, d0_fs, d0_hsync, d0_vsync;
    logic       d1_vid, d1_tick, d1_fs, d1_hsync, d1_vsync;
    logic [3:0] d0_r, d0_g, d0_b, d1_r, d1_g, d1_b;

    vga_timing_gen u_d0 (
        .clk(clk), .reset(rst0),
        .red_in(r0_in), .green_in(g0_in), .blue_in(b0_in),
        .vga_x(d0_x), .vga_y(d0_y), .video_on(d0_vid), .pixel_tick(d0_tick),
        .frame_start(d0_fs), .hsync(d0_hsync), .vsync(d0_vsync),
        .vga_r(d0_r), .vga_g(d0_g), .vga_b(d0_b)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_d1 (
        .clk(clk), .reset(rst1),
        .red_in(r1_in), .green_in(g1_in), .blue_in(b1_in),
        .vga_x(d1_x), .vga_y(d1_y), .video_on(d1_vid), .pixel_tick(d1_tick),
        .frame_start(d1_fs), .hsync(d1_hsync), .vsync(d1_vsync),
        .vga_r(d1_r), .vga_g(d1_g), .vga_b(d1_b)
    );

    // Renderer stand-in: colour is a function of the scan position.
    assign r1_in = d1_x[3:0];
    assign g1_in = d1_y[3:0];
    assign b1_in = 4'hF;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expects div_cnt=0 now with reset just released: tick on the 4th cycle.
    task automatic d0_first_ticks(input string pfx);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_tick%0d", pfx, k), 32'(d0_tick), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("%s_fs%0d", pfx, k), 32'(d0_fs), (k == 3) ? 32'd1 : 32'd0);
            if (k < 3) step();
        end
        check({pfx, "_x_at_tick"}, 32'(d0_x), 32'd0);
        step();
        check({pfx, "_x_after_tick"}, 32'(d0_x), 32'd1);
        check({pfx, "_hsync_after"}, 32'(d0_hsync), 32'd1);
        check({pfx, "_vsync_after"}, 32'(d0_vsync), 32'd1);
    endtask

    logic       p_tick, p_vid, p_hs, p_vs;
    logic [9:0] p_x, p_y, nx, ny;
    logic [3:0] p_r, p_g, p_b;
    int e_vid, e_fs, e_xy, e_hs, e_vs, e_rgb, e_hold, e_d0rst;
    int ticks, first_tick_c, fs_n, fs_c0, fs_c1, fs_t0, fs_t1;
    int hs_low, vs_low, hs_run, vs_run, hs_max, vs_max, b_on;
    int hs_fx, hs_fy, vs_fx, vs_fy, hs0_low, vs0_low, hs0_fx, budget;
    logic hs_fall, vs_fall, hs0_fall, prev_hs0, found;

    initial begin
        {e_vid, e_fs, e_xy, e_hs, e_vs, e_rgb, e_hold, e_d0rst} = '0;
        {ticks, fs_n, fs_c0, fs_c1, fs_t0, fs_t1} = '0;
        {hs_low, vs_low, hs_run, vs_run, hs_max, vs_max, b_on} = '0;
        {hs_fx, hs_fy, vs_fx, vs_fy, hs0_low, vs0_low, hs0_fx} = '0;
        first_tick_c = -1;
        hs_fall = 1'b0; vs_fall = 1'b0; hs0_fall = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;
        r0_in = 4'hF; g0_in = 4'hF; b0_in = 4'hF;

        repeat (5) step();
        check("rst_x", 32'(d0_x), 32'd0);
        check("rst_y", 32'(d0_y), 32'd0);
        check("rst_hsync", 32'(d0_hsync), 32'd1);
        check("rst_vsync", 32'(d0_vsync), 32'd1);
        check("rst_rgb", 32'({d0_r, d0_g, d0_b}), 32'd0);
        check("rst_tick", 32'(d0_tick), 32'd0);
        check("rst_fs", 32'(d0_fs), 32'd0);
        check("rst_d1_tick", 32'(d1_tick), 32'd0);

        // Small raster: two full frames against a per-pixel model.
        rst1 = 1'b0;
        #1;
        for (int c = 0; c < 660; c++) begin
            p_tick = d1_tick; p_x = d1_x; p_y = d1_y;
            p_vid = (d1_x < 10'd8) && (d1_y < 10'd6);
            p_hs = d1_hsync; p_vs = d1_vsync; p_r = d1_r; p_g = d1_g; p_b = d1_b;
            if (d1_vid !== p_vid) e_vid++;
            if (d1_fs !== (d1_tick && d1_x == 10'd0 && d1_y == 10'd0)) e_fs++;
            if (d1_tick && first_tick_c < 0) first_tick_c = c;
            if (d0_tick !== 1'b0 || d0_x !== 10'd0 || d0_hsync !== 1'b1) e_d0rst++;
            if (d1_fs) begin
                if (fs_n == 0) begin fs_c0 = c; fs_t0 = ticks; end
                else if (fs_n == 1) begin fs_c1 = c; fs_t1 = ticks; end
                fs_n++;
            end
            step();
            if (p_tick) begin
                ticks++;
                nx = (p_x == 10'd14) ? 10'd0 : 10'(p_x + 10'd1);
                ny = (p_x != 10'd14) ? p_y : ((p_y == 10'd10) ? 10'd0 : 10'(p_y + 10'd1));
                if (d1_x !== nx || d1_y !== ny) e_xy++;
                if (d1_hsync !== !(p_x >= 10'd10 && p_x <= 10'd12)) e_hs++;
                if (d1_vsync !== !(p_y >= 10'd7 && p_y <= 10'd8)) e_vs++;
                if (d1_r !== (p_vid ? p_x[3:0] : 4'h0) || d1_g !== (p_vid ? p_y[3:0] : 4'h0) ||
                    d1_b !== (p_vid ? 4'hF : 4'h0)) e_rgb++;
                if (!d1_hsync) begin
                    hs_low++; hs_run++;
                    if (hs_run > hs_max) hs_max = hs_run;
                    if (p_hs && !hs_fall) begin hs_fall = 1'b1; hs_fx = int'(p_x); hs_fy = int'(p_y); end
                end else hs_run = 0;
                if (!d1_vsync) begin
                    vs_low++; vs_run++;
                    if (vs_run > vs_max) vs_max = vs_run;
                    if (p_vs && !vs_fall) begin vs_fall = 1'b1; vs_fx = int'(p_x); vs_fy = int'(p_y); end
                end else vs_run = 0;
                if (d1_b == 4'hF) b_on++;
            end else if (d1_x !== p_x || d1_y !== p_y || d1_hsync !== p_hs || d1_vsync !== p_vs ||
                         d1_r !== p_r || d1_g !== p_g || d1_b !== p_b) begin
                e_hold++;
            end
        end
        check("d1_first_tick_cycle", 32'(first_tick_c), 32'd1);
        check("d1_video_on", 32'(e_vid), 32'd0);
        check("d1_frame_start", 32'(e_fs), 32'd0);
        check("d1_xy_step", 32'(e_xy), 32'd0);
        check("d1_hsync_model", 32'(e_hs), 32'd0);
        check("d1_vsync_model", 32'(e_vs), 32'd0);
        check("d1_rgb_model", 32'(e_rgb), 32'd0);
        check("d1_hold_between_ticks", 32'(e_hold), 32'd0);
        check("d0_quiet_in_reset", 32'(e_d0rst), 32'd0);
        check("d1_tick_count", 32'(ticks), 32'd330);
        check("d1_fs_count", 32'(fs_n), 32'd2);
        check("d1_frame_clks", 32'(fs_c1 - fs_c0), 32'd330);
        check("d1_frame_ticks", 32'(fs_t1 - fs_t0), 32'd165);
        check("d1_hsync_low_ticks", 32'(hs_low), 32'd66);
        check("d1_hsync_run", 32'(hs_max), 32'd3);
        check("d1_hsync_fall_x", 32'(hs_fx), 32'd10);
        check("d1_hsync_fall_y", 32'(hs_fy), 32'd0);
        check("d1_vsync_low_ticks", 32'(vs_low), 32'd60);
        check("d1_vsync_run", 32'(vs_max), 32'd30);
        check("d1_vsync_fall_x", 32'(vs_fx), 32'd0);
        check("d1_vsync_fall_y", 32'(vs_fy), 32'd7);
        check("d1_colour_on_ticks", 32'(b_on), 32'd96);

        // Small raster: frame wrap from the last pixel.
        found = 1'b0;
        for (budget = 0; budget < 400 && !found; budget++) begin
            if (d1_tick && d1_x == 10'd14 && d1_y == 10'd10) found = 1'b1;
            else step();
        end
        check("d1_wait_last_pixel", 32'(found), 32'd1);
        step();
        check("d1_wrap_x", 32'(d1_x), 32'd0);
        check("d1_wrap_y", 32'(d1_y), 32'd0);
        found = 1'b0;
        for (budget = 0; budget < 4 && !found; budget++) begin
            if (d1_tick) found = 1'b1;
            else step();
        end
        check("d1_wrap_fs", 32'(found && d1_fs), 32'd1);

        // Default raster: release and first tick.
        rst0 = 1'b0;
        #1;
        d0_first_ticks("rel");

        // Default raster: run to (799,10) counting hsync low cycles on the way.
        found = 1'b0;
        prev_hs0 = d0_hsync;
        for (budget = 0; budget < 40000 && !found; budget++) begin
            if (d0_tick && d0_x == 10'd799 && d0_y == 10'd10) found = 1'b1;
            else begin
                if (!d0_hsync) hs0_low++;
                if (!d0_vsync) vs0_low++;
                if (!d0_hsync && prev_hs0 && !hs0_fall) begin hs0_fall = 1'b1; hs0_fx = int'(d0_x); end
                prev_hs0 = d0_hsync;
                step();
            end
        end
        check("d0_wait_799_10", 32'(found), 32'd1);
        check("d0_hsync_low_clks", 32'(hs0_low), 32'd4224);
        check("d0_hsync_first_low_x", 32'(hs0_fx), 32'd657);
        check("d0_vsync_low_clks", 32'(vs0_low), 32'd0);
        step();
        check("d0_line_wrap_x", 32'(d0_x), 32'd0);
        check("d0_line_wrap_y", 32'(d0_y), 32'd11);
        check("d0_blank_after_799", 32'(d0_r), 32'd0);
        check("d0_hsync_after_799", 32'(d0_hsync), 32'd1);

        // Default raster: reset coincident with the tick at x=300.
        found = 1'b0;
        for (budget = 0; budget < 2000 && !found; budget++) begin
            if (d0_tick && d0_x == 10'd300) found = 1'b1;
            else step();
        end
        check("d0_wait_x300", 32'(found), 32'd1);
        check("d0_active_colour", 32'({d0_r, d0_g, d0_b}), 32'hFFF);
        rst0 = 1'b1;
        #1;
        check("mid_rst_tick_gated", 32'(d0_tick), 32'd0);
        check("mid_rst_fs_gated", 32'(d0_fs), 32'd0);
        step();
        rst0 = 1'b0;
        #1;
        check("mid_rst_x", 32'(d0_x), 32'd0);
        check("mid_rst_y", 32'(d0_y), 32'd0);
        check("mid_rst_div", 32'(u_d0.div_cnt), 32'd0);
        check("mid_rst_hsync", 32'(d0_hsync), 32'd1);
        check("mid_rst_vsync", 32'(d0_vsync), 32'd1);
        check("mid_rst_rgb", 32'({d0_r, d0_g, d0_b}), 32'd0);
        check("mid_rst_video_on", 32'(d0_vid), 32'd1);
        d0_first_ticks("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
